seg7_scan: RTL and testbench

//  Time-multiplexed driver for the board's common-anode 8-digit 7-segment display.
//  - Output-side counterpart of the button debouncer: shows CPU state (PC, register, bus value) as hex digits.
//  - Takes a hex word plus per-digit decimal-point and blank masks, and scans one digit at a time.
//  - Drives active-low anode and segment pins.
//  - Latches the inputs once per frame so a digit never shows a mix of old and new data.

---
 rtl/seg7_scan.sv | 132 +++++++++++++
 tb/tb_seg7_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a common-anode, active-low 7-segment display.
// Input word and masks are captured once per frame, on entry to digit 0.
module seg7_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_CNT = 100000,
  parameter int GAP_CNT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int CMAX = (SCAN_CNT > GAP_CNT) ? SCAN_CNT : GAP_CNT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic                load;

  logic [4*DIGITS-1:0] sh_data, sh_data_next;
  logic [DIGITS-1:0]   sh_dp, sh_dp_next;
  logic [DIGITS-1:0]   sh_blank, sh_blank_next;

  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt + CW'(1);
    load       = 1'b0;

    unique case (state)
      GAP: begin
        if (cnt == CW'(GAP_CNT - 1)) begin
          cnt_next   = '0;
          state_next = DRIVE;
          load       = (idx == '0);
        end
      end
      DRIVE: begin
        if (cnt == CW'(SCAN_CNT - 1)) begin
          cnt_next   = '0;
          state_next = GAP;
          idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
      end
      default: state_next = GAP;
    endcase

    sh_data_next  = load ? data  : sh_data;
    sh_dp_next    = load ? dp    : sh_dp;
    sh_blank_next = load ? blank : sh_blank;

    // Outputs are registered, so they are decoded from the next state and the
    // next shadow; digit 0 therefore shows the word captured on the same edge.
    nib      = sh_data_next[{idx_next, 2'b00} +: 4];
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state_next == DRIVE) begin
      an_next = ~(DIGITS'(1) << idx_next);
      if (!sh_blank_next[idx_next]) begin
        seg_next = hex7(nib);
        dp_next  = ~sh_dp_next[idx_next];
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= GAP;
      idx        <= '0;
      cnt        <= '0;
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      cnt        <= cnt_next;
      an_n       <= an_next;
      seg_n      <= seg_next;
      dp_n       <= dp_next;
      frame_tick <= load;
    end
  end

  // Shadow survives en=0 so a paused display resumes with the same content.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (en) begin
      sh_data  <= sh_data_next;
      sh_dp    <= sh_dp_next;
      sh_blank <= sh_blank_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=8, SCAN_CNT=4, GAP_CNT=1 (40-cycle frame).
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  localparam exp_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};

  logic [6:0] hex_tab [16];

  seg7_scan #(.DIGITS(8), .SCAN_CNT(4), .GAP_CNT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and land on the falling edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  function automatic exp_t observed();
    return '{an: an_n, seg: seg_n, dp: dp_n, tick: frame_tick};
  endfunction

  // Expected outputs at position p of a frame (5 cycles per digit: 4 driven, 1 gap).
  function automatic exp_t expect_at(int p, logic [31:0] d, logic [7:0] dpm, logic [7:0] bl);
    exp_t e;
    int   dig;
    int   s;
    logic [3:0] n;
    dig = p / 5;
    s   = p % 5;
    if (s == 4) return DARK;
    n      = d[4*dig +: 4];
    e.an   = ~(8'h01 << dig);
    e.seg  = bl[dig] ? 7'h7F : hex_tab[n];
    e.dp   = bl[dig] ? 1'b1  : ~dpm[dig];
    e.tick = (p == 0);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (3) step();
    checks++; if (an_n !== 8'hFF) begin fails++; $display("FAIL reset_an_n got %h exp ff", an_n); end
    checks++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg_n got %h exp 7f", seg_n); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp_n got %b exp 1", dp_n); end
    checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
  endtask

  // Two frames of 0123_4567; also measures the frame_tick period.
  task automatic test_scan();
    exp_t e;
    int   t0;
    int   t1;
    t0 = -1; t1 = -1;
    data = 32'h0123_4567; dp = 8'h00; blank = 8'h00;
    rst = 1'b0; en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 40; p++) begin
        step();
        if (frame_tick === 1'b1) begin
          if (t0 < 0) t0 = cycle; else t1 = cycle;
        end
        e = expect_at(p, 32'h0123_4567, 8'h00, 8'h00);
        checks++;
        if (observed() !== e) begin
          fails++;
          $display("FAIL scan f=%0d p=%0d got %h exp %h", f, p, observed(), e);
        end
      end
    end
    checks++;
    if (t1 - t0 !== 40) begin
      fails++;
      $display("FAIL tick_period got %0d exp 40", t1 - t0);
    end
  endtask

  task automatic test_no_tearing();
    exp_t e;
    for (int p = 0; p < 40; p++) begin
      step();
      e = expect_at(p, 32'h0123_4567, 8'h00, 8'h00);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL tear_old p=%0d got %h exp %h", p, observed(), e);
      end
      if (p == 15) data = 32'hFFFF_FFFF;
    end
    for (int p = 0; p < 40; p++) begin
      step();
      e = expect_at(p, 32'hFFFF_FFFF, 8'h00, 8'h00);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL tear_new p=%0d got %h exp %h", p, observed(), e);
      end
    end
  endtask

  task automatic test_dp_blank();
    exp_t e;
    dp = 8'h04; blank = 8'h81;
    for (int p = 0; p < 40; p++) begin
      step();
      e = expect_at(p, 32'hFFFF_FFFF, 8'h04, 8'h81);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL dp_blank p=%0d got %h exp %h", p, observed(), e);
      end
    end
    dp = 8'h00; blank = 8'h00;
  endtask

  task automatic test_abort();
    exp_t e;
    data = 32'h89AB_CDEF;
    // Previous frame's shadow was FFFF_FFFF with dp/blank; new word loads at p=0.
    for (int p = 0; p < 27; p++) begin
      step();
      e = expect_at(p, 32'h89AB_CDEF, 8'h00, 8'h00);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL pre_rst p=%0d got %h exp %h", p, observed(), e);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== DARK) begin fails++; $display("FAIL rst_dark got %h exp %h", observed(), DARK); end
    rst = 1'b0;
    for (int p = 0; p < 40; p++) begin
      step();
      e = expect_at(p, 32'h89AB_CDEF, 8'h00, 8'h00);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL post_rst p=%0d got %h exp %h", p, observed(), e);
      end
    end
    for (int p = 0; p < 27; p++) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (observed() !== DARK) begin fails++; $display("FAIL en_dark k=%0d got %h exp %h", k, observed(), DARK); end
    end
    en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      step();
      e = expect_at(p, 32'h89AB_CDEF, 8'h00, 8'h00);
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL post_en p=%0d got %h exp %h", p, observed(), e);
      end
    end
  endtask

  task automatic test_all_hex();
    exp_t e;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = {8{4'(i)}};
      data = v;
      for (int p = 0; p < 40; p++) begin
        step();
        e = expect_at(p, v, 8'h00, 8'h00);
        checks++;
        if (observed() !== e) begin
          fails++;
          $display("FAIL hex i=%0d p=%0d got %h exp %h", i, p, observed(), e);
        end
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; en = 1'b0;
    data = '0; dp = '0; blank = '0;
    test_reset();
    test_scan();
    test_no_tearing();
    test_dp_blank();
    test_abort();
    test_all_hex();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
